adc_threshold_trigger: RTL and testbench
========================================

# adc_threshold_trigger

Self-trigger stage for one ADC channel. It compares every sample in each incoming ADC word against a threshold and delays the data stream to provide pre-trigger samples. It produces the `TRIGGERED` window plus the hit metadata (time stamp, threshold, baseline) consumed by the downstream header/footer framer. All outputs are registered and cycle-aligned with each other.

## Interface
- `DATA_WIDTH`, 128: ADC word width; holds `DATA_WIDTH/16` sample lanes.
- `ADC_RESOLUTION_WIDTH`, 12: sample width; lane i sample = `DIN[16i+ADC_RESOLUTION_WIDTH-1:16i]`; upper lane bits ignored.
- `TIME_STAMP_WIDTH`, 49: time stamp width.
- `PRE_ACQ_LEN`, 2: words emitted before the first hit word (≥0).
- `POST_ACQ_LEN`, 3: words emitted after the last hit word (≥0).
- `MAX_FRAME_LEN`, 16: maximum consecutive `TRIGGERED` cycles (≥2).

- `CLK` in 1: clock.
- `RESETN` in 1: asynchronous, active-low reset.
- `DIN_VALID` in 1: `DIN` holds a valid word this cycle.
- `DIN` in DATA_WIDTH: ADC word.
- `TIME_STAMP` in TIME_STAMP_WIDTH: free-running time of the current `DIN` word.
- `THRESHOLD` in ADC_RESOLUTION_WIDTH: live hit threshold (unsigned).
- `BASELINE` in ADC_RESOLUTION_WIDTH: live baseline value; latched only.
- `DOUT` out DATA_WIDTH: `DIN` delayed.
- `DOUT_VALID` out 1: `DIN_VALID` delayed identically.
- `TRIGGERED` out 1: acquisition window.
- `TIME_STAMP_WHEN_HIT` out TIME_STAMP_WIDTH: `TIME_STAMP` of the frame's first hit word.
- `THRESHOLD_WHEN_HIT` out ADC_RESOLUTION_WIDTH: `THRESHOLD` at the first hit.
- `BASELINE_WHEN_HIT` out ADC_RESOLUTION_WIDTH: `BASELINE` at the first hit.

## Operation
- Hit: `DIN_VALID`=1 and any lane sample ≥ `THRESHOLD` (unsigned). An invalid word never hits. The comparison always uses the live `THRESHOLD`.
- Delay line: depth PRE_ACQ_LEN+1 words, advancing every cycle regardless of `DIN_VALID`. `DOUT` at cycle c = `DIN` from cycle c−1−PRE_ACQ_LEN. `DOUT_VALID` follows the same rule.
- FSM, evaluated on the current input; results appear at outputs next cycle:
  - IDLE: on a hit → ACQ. Load `hold` = PRE_ACQ_LEN+POST_ACQ_LEN and `len` = 1. Latch `TIME_STAMP`, `THRESHOLD`, `BASELINE`.
  - ACQ (`TRIGGERED`=1):
    - If `len` = MAX_FRAME_LEN → COOLDOWN; this has priority over a hit.
    - Else on a hit → reload `hold`, `len`+1.
    - Else if `hold` = 0 → COOLDOWN.
    - Else `hold`−1, `len`+1.
  - COOLDOWN (`TRIGGERED`=0, exactly one cycle): on a hit → ACQ (reload and latch as from IDLE); else → IDLE.
- Frame length = (t_last−t_first) + PRE_ACQ_LEN + POST_ACQ_LEN + 1, capped at MAX_FRAME_LEN.
- The window covers `DOUT` words w[t_first−PRE] … w[t_last+POST].
- Between frames `TRIGGERED` is low for at least one cycle.
- `*_WHEN_HIT` outputs update only on the cycle `TRIGGERED` rises. They hold through the frame and afterwards.
- Counter widths: `$clog2(MAX_FRAME_LEN+1)` for `len`; `$clog2(PRE+POST+1)` for `hold`, minimum 1 bit.

## Timing
- Reset values, asserted asynchronously:
  - `TRIGGERED`=0, `DOUT_VALID`=0.
  - `DOUT` and delay-line words all ones; delay-line valid bits 0.
  - `*_WHEN_HIT`=0; FSM to IDLE.
- Reset mid-frame ends the frame immediately. There is no footer cycle at this stage.
- Latency: hit at input cycle t → `TRIGGERED` high at t+1. `DOUT` latency is PRE_ACQ_LEN+1 cycles.
- During the first PRE_ACQ_LEN+1 cycles after reset release, `DOUT` is all ones with `DOUT_VALID`=0. This holds even if a frame opens.
- No backpressure: one word per cycle is accepted and emitted.

## Test plan
The following scenarios use PRE=2, POST=3, MAX=16, THRESHOLD=0x400, and hits in lane 3 unless stated; wN is the `DIN` word at cycle N.
- Single hit at cycle 10 (lane 3 = 0x800) → `TRIGGERED` high cycles 11–16. `DOUT` = w8…w13 over those cycles. `TIME_STAMP_WHEN_HIT` = TS@10; `THRESHOLD_WHEN_HIT` = 0x400.
- Hits at cycles 10 and 13 → one frame, high 11–19 (9 cycles). Latched TS remains TS@10.
- Hits every cycle from 10 → high 11–26 (16), low 27, high from 28 with `TIME_STAMP_WHEN_HIT` = TS@27.
- Boundary comparisons, each on an otherwise idle stream:
  - Sample 0x3FF → no trigger.
  - Sample 0x400 → trigger.
  - Sample 0xFFF with `DIN_VALID`=0 → no trigger.
  - Upper 4 lane bits set with sample 0x000 → no trigger.
- Mid-frame change of `THRESHOLD` to 0xFFF with data at 0x800 → frame ends normally after POST+PRE hold. `THRESHOLD_WHEN_HIT` stays 0x400.
- `RESETN` low at cycle 13 during a frame → same cycle: `TRIGGERED`=0, `DOUT` = all ones, `DOUT_VALID`=0. After release on an idle stream, outputs stay idle and `DOUT_VALID` returns 3 cycles after `DIN_VALID`.

Source files
------------

// File: rtl/adc_threshold_trigger.sv
// Self-trigger stage for one ADC channel: per-lane threshold compare, pre-trigger
// delay line, and the TRIGGERED window with hit metadata for the downstream framer.
module adc_threshold_trigger #(
  parameter int DATA_WIDTH           = 128,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int TIME_STAMP_WIDTH     = 49,
  parameter int PRE_ACQ_LEN          = 2,
  parameter int POST_ACQ_LEN         = 3,
  parameter int MAX_FRAME_LEN        = 16
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic                            DIN_VALID,
  input  logic [DATA_WIDTH-1:0]           DIN,
  input  logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] THRESHOLD,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
  output logic [DATA_WIDTH-1:0]           DOUT,
  output logic                            DOUT_VALID,
  output logic                            TRIGGERED,
  output logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP_WHEN_HIT,
  output logic [ADC_RESOLUTION_WIDTH-1:0] THRESHOLD_WHEN_HIT,
  output logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT
);

  localparam int LANES    = DATA_WIDTH / 16;
  localparam int LEN_W    = $clog2(MAX_FRAME_LEN + 1);
  localparam int HOLD_RAW = $clog2(PRE_ACQ_LEN + POST_ACQ_LEN + 1);
  localparam int HOLD_W   = (HOLD_RAW < 1) ? 1 : HOLD_RAW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(PRE_ACQ_LEN + POST_ACQ_LEN);
  localparam logic [LEN_W-1:0]  LEN_MAX     = LEN_W'(MAX_FRAME_LEN);

  logic [DATA_WIDTH-1:0]           dly_data_q [0:PRE_ACQ_LEN];
  logic [DATA_WIDTH-1:0]           dly_data_d [0:PRE_ACQ_LEN];
  logic [PRE_ACQ_LEN:0]            dly_vld_q, dly_vld_d;
  logic [1:0]                      state_q, state_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic                            trig_q, trig_d;
  logic [TIME_STAMP_WIDTH-1:0]     ts_q, ts_d;
  logic [ADC_RESOLUTION_WIDTH-1:0] thr_q, thr_d;
  logic [ADC_RESOLUTION_WIDTH-1:0] bl_q, bl_d;
  logic                            any_lane_s;
  logic                            hit_s;
  logic                            latch_s;

  // Hit detection: only the low ADC_RESOLUTION_WIDTH bits of each 16-bit lane count.
  always_comb begin
    any_lane_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      any_lane_s = any_lane_s | (DIN[16*i +: ADC_RESOLUTION_WIDTH] >= THRESHOLD);
    end
    hit_s = DIN_VALID & any_lane_s;
  end

  // Delay line shifts every cycle regardless of DIN_VALID.
  always_comb begin
    dly_data_d[0] = DIN;
    dly_vld_d[0]  = DIN_VALID;
    for (int i = 1; i <= PRE_ACQ_LEN; i++) begin
      dly_data_d[i] = dly_data_q[i-1];
      dly_vld_d[i]  = dly_vld_q[i-1];
    end
  end

  // Frame FSM; the length cap wins over a hit so frames never exceed MAX_FRAME_LEN.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_COOL: begin
        if (hit_s) begin
          state_d = ST_ACQ;
          hold_d  = HOLD_RELOAD;
          len_d   = LEN_W'(1);
          latch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACQ: begin
        if (len_q == LEN_MAX) begin
          state_d = ST_COOL;
        end else if (hit_s) begin
          hold_d = HOLD_RELOAD;
          len_d  = len_q + LEN_W'(1);
        end else if (hold_q == HOLD_W'(0)) begin
          state_d = ST_COOL;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          len_d  = len_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    trig_d = (state_d == ST_ACQ);
    ts_d   = latch_s ? TIME_STAMP : ts_q;
    thr_d  = latch_s ? THRESHOLD  : thr_q;
    bl_d   = latch_s ? BASELINE   : bl_q;
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i <= PRE_ACQ_LEN; i++) begin
        dly_data_q[i] <= {DATA_WIDTH{1'b1}};
      end
      dly_vld_q <= '0;
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      len_q     <= '0;
      trig_q    <= 1'b0;
      ts_q      <= '0;
      thr_q     <= '0;
      bl_q      <= '0;
    end else begin
      for (int i = 0; i <= PRE_ACQ_LEN; i++) begin
        dly_data_q[i] <= dly_data_d[i];
      end
      dly_vld_q <= dly_vld_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      len_q     <= len_d;
      trig_q    <= trig_d;
      ts_q      <= ts_d;
      thr_q     <= thr_d;
      bl_q      <= bl_d;
    end
  end

  assign DOUT                = dly_data_q[PRE_ACQ_LEN];
  assign DOUT_VALID          = dly_vld_q[PRE_ACQ_LEN];
  assign TRIGGERED           = trig_q;
  assign TIME_STAMP_WHEN_HIT = ts_q;
  assign THRESHOLD_WHEN_HIT  = thr_q;
  assign BASELINE_WHEN_HIT   = bl_q;

endmodule

// File: tb/tb_adc_threshold_trigger.sv
// Directed bench for adc_threshold_trigger (PRE=2, POST=3, MAX=16, 8 lanes).
module tb_adc_threshold_trigger;

  localparam int NC = 48;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         DIN_VALID = 1'b0;
  logic [127:0] DIN = '0;
  logic [48:0]  TIME_STAMP = '0;
  logic [11:0]  THRESHOLD = 12'h400;
  logic [11:0]  BASELINE = 12'h000;
  logic [127:0] DOUT;
  logic         DOUT_VALID;
  logic         TRIGGERED;
  logic [48:0]  TIME_STAMP_WHEN_HIT;
  logic [11:0]  THRESHOLD_WHEN_HIT;
  logic [11:0]  BASELINE_WHEN_HIT;

  adc_threshold_trigger dut (
    .CLK(CLK), .RESETN(RESETN), .DIN_VALID(DIN_VALID), .DIN(DIN),
    .TIME_STAMP(TIME_STAMP), .THRESHOLD(THRESHOLD), .BASELINE(BASELINE),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .TRIGGERED(TRIGGERED),
    .TIME_STAMP_WHEN_HIT(TIME_STAMP_WHEN_HIT),
    .THRESHOLD_WHEN_HIT(THRESHOLD_WHEN_HIT),
    .BASELINE_WHEN_HIT(BASELINE_WHEN_HIT)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] s_din [NC];
  logic         s_vld [NC];
  logic [11:0]  s_thr [NC];
  logic         r_trig [NC];
  logic [127:0] r_dout [NC];
  logic         r_dv [NC];
  logic [48:0]  r_ts [NC];
  logic [11:0]  r_thr [NC];
  logic [11:0]  r_bl [NC];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Background words keep every lane below 0x400 and unique per cycle.
  function automatic logic [127:0] word(input int c);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = 16'((c * 8 + i) & 16'h03FF);
    return w;
  endfunction

  function automatic logic [127:0] with_lane3(input int c, input logic [15:0] v);
    logic [127:0] w;
    w = word(c);
    w[63:48] = v;
    return w;
  endfunction

  function automatic logic [48:0] ts_of(input int c);
    return 49'h1_2345_6700_0000 + 49'(c);
  endfunction

  function automatic logic [11:0] bl_of(input int c);
    return 12'h100 + 12'(c);
  endfunction

  task automatic stim_idle();
    for (int c = 0; c < NC; c++) begin
      s_din[c] = word(c);
      s_vld[c] = 1'b1;
      s_thr[c] = 12'h400;
    end
  endtask

  task automatic drive(input int c);
    DIN        = s_din[c];
    DIN_VALID  = s_vld[c];
    THRESHOLD  = s_thr[c];
    TIME_STAMP = ts_of(c);
    BASELINE   = bl_of(c);
  endtask

  task automatic record(input int c);
    r_trig[c] = TRIGGERED;
    r_dout[c] = DOUT;
    r_dv[c]   = DOUT_VALID;
    r_ts[c]   = TIME_STAMP_WHEN_HIT;
    r_thr[c]  = THRESHOLD_WHEN_HIT;
    r_bl[c]   = BASELINE_WHEN_HIT;
  endtask

  // Reset, then play ncyc stimulus cycles; r_*[c] holds outputs seen during cycle c.
  task automatic run(input int ncyc);
    RESETN = 1'b0;
    drive(0);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    record(0);
    for (int c = 0; c < ncyc; c++) begin
      drive(c);
      @(posedge CLK);
      #1;
      record(c + 1);
    end
  endtask

  task automatic chk_trig(input string name, input int ncyc, input int lo0, input int hi0,
                          input int lo1, input int hi1);
    for (int c = 0; c <= ncyc; c++)
      chk($sformatf("%s.trig@%0d", name, c), 128'(r_trig[c]),
          128'(((c >= lo0) && (c <= hi0)) || ((c >= lo1) && (c <= hi1))));
  endtask

  int r0;

  initial begin
    // Single hit at 10: window 11..16, DOUT lags by 3, metadata from cycle 10.
    stim_idle();
    s_din[10] = with_lane3(10, 16'h0800);
    run(24);
    chk_trig("single", 24, 11, 16, -1, -1);
    for (int c = 0; c <= 24; c++) begin
      chk($sformatf("single.dout@%0d", c), r_dout[c], (c < 3) ? {128{1'b1}} : s_din[c-3]);
      chk($sformatf("single.dv@%0d", c), 128'(r_dv[c]), 128'(c >= 3));
    end
    chk("single.reset_ts", 128'(r_ts[0]), 128'(0));
    chk("single.ts_before", 128'(r_ts[10]), 128'(0));
    chk("single.ts", 128'(r_ts[11]), 128'(ts_of(10)));
    chk("single.ts_after", 128'(r_ts[24]), 128'(ts_of(10)));
    chk("single.thr", 128'(r_thr[11]), 128'(12'h400));
    chk("single.bl", 128'(r_bl[16]), 128'(bl_of(10)));

    // Hits at 10 and 13 merge into one 9-cycle frame.
    stim_idle();
    s_din[10] = with_lane3(10, 16'h0800);
    s_din[13] = with_lane3(13, 16'h0800);
    run(24);
    chk_trig("double", 24, 11, 19, -1, -1);
    chk("double.ts", 128'(r_ts[19]), 128'(ts_of(10)));

    // Continuous hits: capped at 16, one low cycle, new frame latches cycle 27.
    stim_idle();
    for (int c = 10; c < NC; c++) s_din[c] = with_lane3(c, 16'h0800);
    run(32);
    chk_trig("cont", 32, 11, 26, 28, 32);
    chk("cont.ts_first", 128'(r_ts[26]), 128'(ts_of(10)));
    chk("cont.ts_second", 128'(r_ts[28]), 128'(ts_of(27)));
    chk("cont.bl_second", 128'(r_bl[28]), 128'(bl_of(27)));

    // Threshold boundaries, one pulse at cycle 5.
    stim_idle();
    s_din[5] = with_lane3(5, 16'h03FF);
    run(14);
    chk_trig("b3ff", 14, -1, -1, -1, -1);

    stim_idle();
    s_din[5] = with_lane3(5, 16'h0400);
    run(14);
    chk_trig("b400", 14, 6, 11, -1, -1);

    stim_idle();
    s_din[5] = with_lane3(5, 16'h0FFF);
    s_vld[5] = 1'b0;
    run(14);
    chk_trig("binv", 14, -1, -1, -1, -1);
    chk("binv.dv7", 128'(r_dv[7]), 128'(1));
    chk("binv.dv8", 128'(r_dv[8]), 128'(0));
    chk("binv.dv9", 128'(r_dv[9]), 128'(1));

    stim_idle();
    s_din[5] = with_lane3(5, 16'hF000);
    run(14);
    chk_trig("bupper", 14, -1, -1, -1, -1);

    // Threshold raised at 12 with data held at 0x800: last hit 11, window 11..17.
    stim_idle();
    for (int c = 10; c < NC; c++) s_din[c] = with_lane3(c, 16'h0800);
    for (int c = 12; c < NC; c++) s_thr[c] = 12'hFFF;
    run(22);
    chk_trig("thrchg", 22, 11, 17, -1, -1);
    chk("thrchg.thr", 128'(r_thr[22]), 128'(12'h400));

    // Reset during a frame at cycle 13, then idle stream with late valid.
    stim_idle();
    s_din[10] = with_lane3(10, 16'h0800);
    run(13);
    chk("rst.trig_pre", 128'(r_trig[13]), 128'(1));
    RESETN = 1'b0;
    #1;
    chk("rst.trig", 128'(TRIGGERED), 128'(0));
    chk("rst.dout", DOUT, {128{1'b1}});
    chk("rst.dv", 128'(DOUT_VALID), 128'(0));
    chk("rst.ts", 128'(TIME_STAMP_WHEN_HIT), 128'(0));
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    r0 = 0;
    for (int c = 0; c < 12; c++) begin
      DIN       = word(c);
      DIN_VALID = (c >= 5);
      THRESHOLD = 12'h400;
      @(posedge CLK);
      #1;
      r0 = c + 1;
      chk($sformatf("post.trig@%0d", r0), 128'(TRIGGERED), 128'(0));
      chk($sformatf("post.dv@%0d", r0), 128'(DOUT_VALID), 128'(r0 >= 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
